// File: rtl/mac_lane_seq_pkg.sv
// Shared types and helpers for the MAC lane sequencer.
package mac_lane_seq_pkg;

  localparam int LANES = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_res_t;

  // Signed add of two sign-extended operands, clamped to a w-bit signed range.
  // ovf flags that clamping took place.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (sum < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end else begin
      r.val = sum;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_seq_vld_pipe.sv
// Valid-tag delay line: marks the cycle on which an issued tile's lane_f returns.
module mac_lane_vld_pipe #(
  parameter int LANE_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_vld,
  output logic out_vld
);

  logic [LANE_LAT-1:0] sr;

  generate
    if (LANE_LAT == 1) begin : g_one
      // Single-stage tag register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '0;
        else       sr[0] <= in_vld;
      end
    end else begin : g_multi
      // Multi-stage tag shift register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= {sr[LANE_LAT-2:0], in_vld};
      end
    end
  endgenerate

  assign out_vld = sr[LANE_LAT-1];

endmodule

// File: rtl/mac_lane_seq.sv
// Dot-product sequencer: feeds tiles to an external 16-wide MAC lane and
// accumulates the returned partial results with saturation.
module mac_lane_seq
  import mac_lane_seq_pkg::*;
#(
  parameter int IL       = 4,
  parameter int FL       = 16,
  parameter int LANE_LAT = 1,
  localparam int W       = IL + FL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4:0]         cmd_tiles,
  input  logic               tile_valid,
  output logic               tile_ready,
  input  logic [LANES*W-1:0] tile_i,
  input  logic [LANES*W-1:0] tile_w,
  output logic [LANES*W-1:0] lane_i,
  output logic [LANES*W-1:0] lane_w,
  input  logic [W-1:0]       lane_f,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_data,
  output logic               res_sat
);

  state_t     state, state_nx;
  logic [4:0] n_tiles;
  logic [4:0] iss_cnt;
  logic [4:0] ret_cnt;
  logic [W-1:0] acc;
  logic       sat;
  logic       lane_vld;
  logic       tag;
  logic       cmd_acc;
  logic       tile_acc;
  sat_res_t   sum;

  assign cmd_acc  = cmd_valid & cmd_ready;
  assign tile_acc = tile_valid & tile_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    tile_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_FEED;
      end
      S_FEED: begin
        tile_ready = 1'b1;
        if (tile_valid && (iss_cnt + 5'd1 == n_tiles)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (ret_cnt == n_tiles) state_nx = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Lane operand registers; idle cycles present zeros to the lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_i   <= '0;
      lane_w   <= '0;
      lane_vld <= 1'b0;
    end else begin
      lane_i   <= tile_acc ? tile_i : '0;
      lane_w   <= tile_acc ? tile_w : '0;
      lane_vld <= tile_acc;
    end
  end

  mac_lane_vld_pipe #(.LANE_LAT(LANE_LAT)) u_vld_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (lane_vld),
    .out_vld (tag)
  );

  always_comb sum = sat_add({{(64-W){acc[W-1]}}, acc}, {{(64-W){lane_f[W-1]}}, lane_f}, W);

  // Command latch, issue/return counters and saturating accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_tiles <= 5'd1;
      iss_cnt <= '0;
      ret_cnt <= '0;
      acc     <= '0;
      sat     <= 1'b0;
    end else if (cmd_acc) begin
      n_tiles <= (cmd_tiles == 5'd0) ? 5'd1 : cmd_tiles;
      iss_cnt <= '0;
      ret_cnt <= '0;
      acc     <= '0;
      sat     <= 1'b0;
    end else begin
      if (tile_acc) iss_cnt <= iss_cnt + 5'd1;
      if (tag) begin
        acc     <= sum.val[W-1:0];
        sat     <= sat | sum.ovf;
        ret_cnt <= ret_cnt + 5'd1;
      end
    end
  end

  assign res_data = acc;
  assign res_sat  = sat;

endmodule

// File: tb/tb_mac_lane_seq.sv
module tb_mac_lane_seq;
  localparam int IL = 4;
  localparam int FL = 16;
  localparam int LL = 2;
  localparam int W  = IL + FL;
  localparam int N  = 16;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [4:0]     cmd_tiles = '0;
  logic           tile_valid = 1'b0;
  logic           tile_ready;
  logic [N*W-1:0] tile_i = '0;
  logic [N*W-1:0] tile_w = '0;
  logic [N*W-1:0] lane_i;
  logic [N*W-1:0] lane_w;
  logic [W-1:0]   lane_f;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_data;
  logic           res_sat;

  mac_lane_seq #(.IL(IL), .FL(FL), .LANE_LAT(LL)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tiles(cmd_tiles), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_i(tile_i), .tile_w(tile_w), .lane_i(lane_i), .lane_w(lane_w),
    .lane_f(lane_f), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sat(res_sat)
  );

  always #5 clk = ~clk;

  // External lane: fixed-point dot product, truncated to W bits.
  function automatic logic [W-1:0] lane_ref(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    longint s;
    logic signed [W-1:0] ea, eb;
    s = 0;
    for (int k = 0; k < N; k++) begin
      ea = a[k*W +: W];
      eb = b[k*W +: W];
      s += longint'(ea) * longint'(eb);
    end
    s = s >>> FL;
    return s[W-1:0];
  endfunction

  logic [W-1:0] f_d1 = '0, f_d2 = '0;
  always @(posedge clk) begin
    f_d1 <= lane_ref(lane_i, lane_w);
    f_d2 <= f_d1;
  end
  assign lane_f = f_d2;

  typedef struct {
    logic [W-1:0] data;
    bit           sat;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops an expectation on every result handshake.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", res_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("res_data", 64'(res_data), 64'(e.data));
        check("res_sat", 64'(res_sat), 64'(e.sat));
      end
    end
  end

  logic [N*W-1:0] ti_arr[N];
  logic [N*W-1:0] tw_arr[N];
  int             bub_arr[N];

  task automatic clear_tiles();
    for (int t = 0; t < N; t++) begin
      ti_arr[t] = '0;
      tw_arr[t] = '0;
      bub_arr[t] = 0;
    end
  endtask

  task automatic run_cmd(input int field, input int hold, input bit chk_lat);
    int n, lat;
    longint acc;
    bit sat;
    exp_t e;
    logic signed [W-1:0] f;
    n = (field == 0) ? 1 : field;
    acc = 0;
    sat = 0;
    for (int t = 0; t < n; t++) begin
      f = lane_ref(ti_arr[t], tw_arr[t]);
      acc += longint'(f);
      if (acc > MAXV) begin acc = MAXV; sat = 1; end
      if (acc < MINV) begin acc = MINV; sat = 1; end
    end
    e.data = acc[W-1:0];
    e.sat = sat;
    q.push_back(e);

    @(posedge clk); #1;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_tiles = field[4:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    for (int t = 0; t < n; t++) begin
      tile_valid = 1'b0;
      for (int b = 0; b < bub_arr[t]; b++) begin
        @(posedge clk); #1;
        lat++;
      end
      tile_valid = 1'b1;
      tile_i = ti_arr[t];
      tile_w = tw_arr[t];
      @(posedge clk); #1;
      lat++;
    end
    tile_valid = 1'b0;
    tile_i = '0;
    tile_w = '0;
    check("tile_ready_after_last", 64'(tile_ready), 64'd0);
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("res_valid_seen", 64'(res_valid), 64'd1);
    if (chk_lat) check("latency", 64'(lat), 64'(n + LL + 2));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data", 64'(res_data), 64'(e.data));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_clear", 64'(res_valid), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int tmp, field, big;
    bit nobub;
    clear_tiles();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_tile_ready", 64'(tile_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_sat", 64'(res_sat), 64'd0);
    check("rst_lane_i", 64'(lane_i[63:0]), 64'd0);
    reset = 1'b0;

    // One tile: i_k = k<<10, w_k = (k+1)<<10.
    for (int k = 0; k < N; k++) begin
      tmp = k << 10;
      ti_arr[0][k*W +: W] = tmp[W-1:0];
      tmp = (k + 1) << 10;
      tw_arr[0][k*W +: W] = tmp[W-1:0];
    end
    run_cmd(1, 1, 1);
    check("one_tile_value", 64'(res_data), 64'h05500);

    // Same tile twice with a bubble between.
    ti_arr[1] = ti_arr[0];
    tw_arr[1] = tw_arr[0];
    bub_arr[1] = 1;
    run_cmd(2, 1, 0);
    check("two_tile_value", 64'(res_data), 64'h0AA00);

    // Positive overflow, result held for 10 cycles.
    clear_tiles();
    ti_arr[0][W-1:0] = 20'h20000;
    tw_arr[0][W-1:0] = 20'h20000;
    ti_arr[1] = ti_arr[0];
    tw_arr[1] = tw_arr[0];
    run_cmd(2, 10, 1);
    check("sat_value", 64'(res_data), 64'h7FFFF);
    check("sat_flag", 64'(res_sat), 64'd1);

    // Reset while one tile is in flight in DRAIN.
    clear_tiles();
    ti_arr[0][W-1:0] = 20'h10000;
    tw_arr[0][W-1:0] = 20'h30000;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_tiles = 5'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tile_valid = 1'b1;
    tile_i = ti_arr[0];
    tile_w = tw_arr[0];
    @(posedge clk); #1;
    tile_valid = 1'b0;
    tile_i = '0;
    tile_w = '0;
    reset = 1'b1;
    #1;
    check("abort_res_valid", 64'(res_valid), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_res_data", 64'(res_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_tiles();
    ti_arr[0][W-1:0] = 20'h08000;
    tw_arr[0][W-1:0] = 20'h00400;
    run_cmd(1, 0, 1);

    // cmd_tiles = 0 behaves as a single tile.
    clear_tiles();
    for (int k = 0; k < N; k++) begin
      tmp = int'($urandom_range(0, 8191)) - 4096;
      ti_arr[0][k*W +: W] = tmp[W-1:0];
      tmp = int'($urandom_range(0, 8191)) - 4096;
      tw_arr[0][k*W +: W] = tmp[W-1:0];
    end
    run_cmd(0, 2, 1);

    // Randomised commands.
    for (int it = 0; it < 12; it++) begin
      clear_tiles();
      field = int'($urandom_range(0, 16));
      big = int'($urandom_range(0, 3));
      nobub = 1;
      for (int t = 0; t < N; t++) begin
        for (int k = 0; k < N; k++) begin
          if (big == 0) begin
            ti_arr[t][k*W +: W] = W'($urandom);
            tw_arr[t][k*W +: W] = W'($urandom);
          end else begin
            tmp = int'($urandom_range(0, 8191)) - 4096;
            ti_arr[t][k*W +: W] = tmp[W-1:0];
            tmp = int'($urandom_range(0, 8191)) - 4096;
            tw_arr[t][k*W +: W] = tmp[W-1:0];
          end
        end
        bub_arr[t] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
        if (bub_arr[t] != 0) nobub = 0;
      end
      run_cmd(field, int'($urandom_range(0, 3)), nobub);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_lane_seq.md
MAC_LANE_SEQ -- requirements
Module: mac_lane_seq

Interface
REQ-001 SHALL have parameter IL, default 4, meaning integer bits of the signed fixed-point format.
REQ-002 SHALL have parameter FL, default 16, meaning fractional bits; word width W = IL+FL.
REQ-003 SHALL have parameter LANE_LAT, default 1, meaning cycles from lane_i/lane_w registered to matching lane_f valid.
REQ-004 SHALL have one clock, clk, and an asynchronous active-high reset, reset.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 cmd_valid  input  1  new dot-product command offered.
REQ-008 cmd_ready  output  1  controller idle, accepts command.
REQ-009 cmd_tiles  input  5  number of 16-element tiles, 1..16.
REQ-010 tile_valid  input  1  tile operands offered.
REQ-011 tile_ready  output  1  controller accepts tile.
REQ-012 tile_i  input  16*W  packed signed inputs, element k at bits [k*W +: W].
REQ-013 tile_w  input  16*W  packed signed weights, same packing.
REQ-014 lane_i  output  16*W  registered inputs to the external 16-wide MAC lane.
REQ-015 lane_w  output  16*W  registered weights to the MAC lane.
REQ-016 lane_f  input  W  lane dot-product result, LANE_LAT cycles after lane_i/lane_w.
REQ-017 res_valid  output  1  accumulated result available.
REQ-018 res_ready  input  1  consumer takes result.
REQ-019 res_data  output  W  saturated sum of all tile results.
REQ-020 res_sat  output  1  saturation occurred during this command.

Function
REQ-021 SHALL implement states IDLE, FEED, DRAIN, DONE.
REQ-022 IDLE: cmd_ready=1; cmd_valid=1 latches cmd_tiles, clears accumulator, issue and return counters and res_sat, goes FEED.
REQ-023 cmd_tiles=0 SHALL be treated as 1.
REQ-024 FEED: tile_ready=1; each tile_valid&tile_ready beat registers tile_i/tile_w onto lane_i/lane_w next cycle and increments the issue count.
REQ-025 Cycles without an accepted tile SHALL drive lane_i/lane_w to zero; tile_valid bubbles are permitted.
REQ-026 A LANE_LAT-deep valid shift register SHALL tag each issued tile; lane_f is accumulated only on a tagged cycle.
REQ-027 After the last tile is accepted, FEED SHALL go DRAIN; tile_ready=0 outside FEED.
REQ-028 DRAIN goes DONE in the cycle after the return count reaches the latched tile count.
REQ-029 Accumulation: signed add of lane_f into a W-bit accumulator, saturating to 0x7..F or 0x8..0 (W bits), setting res_sat sticky.
REQ-030 DONE: res_valid=1, res_data/res_sat held stable until res_ready=1, then go IDLE.
REQ-031 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0).
REQ-032 Command-to-result latency with no bubbles SHALL be tiles + LANE_LAT + 2 cycles from cmd accept.

Reset
REQ-033 Reset SHALL force state IDLE, cmd_ready=1, tile_ready=0, res_valid=0, res_data=0, res_sat=0, lane_i/lane_w=0, counters and valid shift register cleared.
REQ-034 Reset mid-command SHALL abandon the command; in-flight lane results SHALL not be accumulated afterwards.

Structure
REQ-035 Shared package SHALL hold the state enum, lane width constant 16, and saturating-add function.
REQ-036 The valid-tag delay line SHALL be a sub-module mac_lane_vld_pipe parameterised by LANE_LAT.
REQ-037 The MAC lane itself SHALL remain external, connected at the parent level.

Verification (IL=4, FL=16, LANE_LAT=2, lane model computing sum(i*w)>>FL)
REQ-038 One tile, i_k=k<<10, w_k=(k+1)<<10 -> res_data=0x05500, res_sat=0, res_valid 5 cycles after cmd accept.
REQ-039 Same tile twice with one tile_valid bubble between -> res_data=0x0AA00, res_sat=0.
REQ-040 Two tiles, i_0=w_0=0x20000, rest zero -> per-tile f=0x40000; res_data=0x7FFFF, res_sat=1.
REQ-041 res_ready held low 10 cycles in DONE -> res_valid and res_data stable; cmd_ready=0 throughout.
REQ-042 Reset asserted in DRAIN with 1 tile in flight -> IDLE next edge, res_valid=0; following 1-tile command returns only its own sum.
REQ-043 cmd_tiles=0 -> exactly one tile accepted, result equals that tile's lane_f.
